// File: rtl/xmul_issue_q.sv
// Ready/valid front-end for the xmul multiply-accumulate unit: command FIFO, credit-gated
// in-order issue into a fixed-latency multiplier, and an in-order response FIFO.
module xmul_issue_q #(
  parameter int unsigned CDEPTH  = 4,
  parameter int unsigned RDEPTH  = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dw,
  input  logic [5:0]  cmd_fn,
  input  logic [4:0]  cmd_tag,
  input  logic [63:0] cmd_in1,
  input  logic [63:0] cmd_in2,
  input  logic [63:0] cmd_in3,
  output logic        mul_req_valid,
  output logic        mul_req_dw,
  output logic [5:0]  mul_req_fn,
  output logic [4:0]  mul_req_tag,
  output logic [63:0] mul_req_in1,
  output logic [63:0] mul_req_in2,
  output logic [63:0] mul_req_in3,
  input  logic [63:0] mul_resp_data,
  input  logic [4:0]  mul_resp_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned CAW  = $clog2(CDEPTH);
  localparam int unsigned RAW  = $clog2(RDEPTH);
  localparam int unsigned INW  = $clog2(MUL_LAT + 1);
  localparam int unsigned SUMW = $clog2(RDEPTH + MUL_LAT + 1) + 1;

  typedef struct packed {
    logic        dw;
    logic [5:0]  fn;
    logic [4:0]  tag;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] in3;
  } cmd_t;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        err;
  } rsp_t;

  function automatic logic fn_legal(input logic [5:0] fn);
    case (fn)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd50, 6'd51, 6'd52: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  cmd_t               cmd_mem [CDEPTH];
  logic [CAW:0]       cmd_wr_ptr, cmd_rd_ptr, cmd_count;
  cmd_t               cmd_in, cmd_head;
  logic               cmd_push, issue, head_err;

  rsp_t               rsp_mem [RDEPTH];
  logic [RAW:0]       rsp_wr_ptr, rsp_rd_ptr, rsp_count;
  rsp_t               rsp_in, rsp_head;
  logic               rsp_push, rsp_pop;

  logic [MUL_LAT-1:0] stage_v, stage_e;
  logic [INW-1:0]     inflight_count;
  logic               credit_ok;

  assign cmd_in   = '{dw: cmd_dw, fn: cmd_fn, tag: cmd_tag, in1: cmd_in1, in2: cmd_in2, in3: cmd_in3};
  assign cmd_count = cmd_wr_ptr - cmd_rd_ptr;
  assign cmd_ready = cmd_count < (CAW+1)'(CDEPTH);
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_head  = cmd_mem[cmd_rd_ptr[CAW-1:0]];
  assign head_err  = ~fn_legal(cmd_head.fn);

  // Issue only when the response FIFO is guaranteed room for everything already in flight.
  assign rsp_count      = rsp_wr_ptr - rsp_rd_ptr;
  assign inflight_count = INW'($countones(stage_v));
  assign credit_ok      = (SUMW'(rsp_count) + SUMW'(inflight_count)) < SUMW'(RDEPTH);
  assign issue          = (cmd_count != '0) & credit_ok;

  // Illegal functions go out as a zero MUL so the slot and ordering are preserved.
  always_comb begin
    mul_req_valid = 1'b0;
    mul_req_dw    = 1'b0;
    mul_req_fn    = '0;
    mul_req_tag   = '0;
    mul_req_in1   = '0;
    mul_req_in2   = '0;
    mul_req_in3   = '0;
    if (issue) begin
      mul_req_valid = 1'b1;
      mul_req_dw    = cmd_head.dw;
      mul_req_tag   = cmd_head.tag;
      if (!head_err) begin
        mul_req_fn  = cmd_head.fn;
        mul_req_in1 = cmd_head.in1;
        mul_req_in2 = cmd_head.in2;
        mul_req_in3 = cmd_head.in3;
      end
    end
  end

  assign rsp_push = stage_v[MUL_LAT-1];
  assign rsp_in   = '{data: stage_e[MUL_LAT-1] ? 64'd0 : mul_resp_data,
                      tag:  mul_resp_tag,
                      err:  stage_e[MUL_LAT-1]};
  assign rsp_valid = rsp_count != '0;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd_ptr[RAW-1:0]];

  always_comb begin
    rsp_data = '0;
    rsp_tag  = '0;
    rsp_err  = 1'b0;
    if (rsp_valid) begin
      rsp_data = rsp_head.data;
      rsp_tag  = rsp_head.tag;
      rsp_err  = rsp_head.err;
    end
  end

  assign busy = (cmd_count != '0) | (inflight_count != '0) | (rsp_count != '0);

  // Pointers and in-flight shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      stage_v    <= '0;
      stage_e    <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + (CAW+1)'(1);
      if (issue)    cmd_rd_ptr <= cmd_rd_ptr + (CAW+1)'(1);
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + (RAW+1)'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + (RAW+1)'(1);
      stage_v[0] <= issue;
      stage_e[0] <= issue & head_err;
      for (int i = 1; i < MUL_LAT; i++) begin
        stage_v[i] <= stage_v[i-1];
        stage_e[i] <= stage_e[i-1];
      end
    end
  end

  // FIFO storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clock) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr[CAW-1:0]] <= cmd_in;
    if (rsp_push) rsp_mem[rsp_wr_ptr[RAW-1:0]] <= rsp_in;
  end

endmodule
